packet_order_arb: RTL and testbench

PACKET_ORDER_ARB -- requirements
Module: packet_order_arb

---
 rtl/packet_order_arb.sv | 182 ++++++++++++++++++
 tb/tb_packet_order_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_order_arb.sv
// packet_order_arb: in-order result arbiter for one node of a splitter tree.
// A small FIFO remembers which child (left/right) each committed packet went
// to; results are forwarded to the parent strictly in that order.
// Optional build macro PACKET_ORDER_ARB_STATS_EN adds a 32-bit fwd_count
// output counting forwarded (popped) packets.
module packet_order_arb #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic choice_push,
   input  logic choice_in,
   output logic full,
   input  logic rdy_left,
   input  logic rdy_right,
   input  logic grant_in,
   output logic rdy_out,
   output logic sel_left,
   output logic sel_right,
   input  logic done_fwd,
   output logic done_left,
   output logic done_right,
   output logic overflow
`ifdef PACKET_ORDER_ARB_STATS_EN
   ,
   output logic [31:0] fwd_count
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  mem_q [DEPTH];
   logic                  mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  sel_left_q, sel_left_d;
   logic                  sel_right_q, sel_right_d;
   logic                  overflow_q, overflow_d;

   logic head;
   logic head_rdy;
   logic push_acc;
   logic pop;

   // Head choice and the readiness of the child it points at
   always_comb begin
      head     = mem_q[rd_ptr_q];
      head_rdy = head ? rdy_right : rdy_left;
      // A push only looks at the pre-edge count, so a pop in the same
      // cycle does not make room for it.
      push_acc = choice_push && (count_q < DEPTH_C);
      pop      = (state_q == GRANT) && done_fwd;
   end

   // FIFO storage, pointers, count and sticky overflow
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push_acc) begin
         mem_d[wr_ptr_q] = choice_in;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (choice_push && !push_acc) begin
         overflow_d = 1'b1;
      end
   end

   // Grant FSM: IDLE until something is queued, WAIT offers the head
   // upstream, GRANT holds the route until the forwarder reports done
   always_comb begin
      state_d     = state_q;
      sel_left_d  = sel_left_q;
      sel_right_d = sel_right_q;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (head_rdy && grant_in) begin
               state_d     = GRANT;
               sel_left_d  = !head;
               sel_right_d = head;
            end
         end
         GRANT: begin
            if (done_fwd) begin
               sel_left_d  = 1'b0;
               sel_right_d = 1'b0;
               state_d     = (count_d != '0) ? WAIT : IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            sel_left_d  = 1'b0;
            sel_right_d = 1'b0;
         end
      endcase
   end

   // Control registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sel_left_q  <= 1'b0;
         sel_right_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sel_left_q  <= sel_left_d;
         sel_right_q <= sel_right_d;
         overflow_q  <= overflow_d;
      end
   end

   // Choice storage needs no reset: entries are only read once counted
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

`ifdef PACKET_ORDER_ARB_STATS_EN
   logic [31:0] fwd_count_q, fwd_count_d;

   // Forwarded-packet counter, wraps naturally at 32 bits
   always_comb begin
      fwd_count_d = fwd_count_q;
      if (pop) begin
         fwd_count_d = fwd_count_q + 32'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_count_q <= '0;
      end else begin
         fwd_count_q <= fwd_count_d;
      end
   end

   assign fwd_count = fwd_count_q;
`endif

   // Outputs are forced low while reset is held
   always_comb begin
      full       = rst_n && (count_q == DEPTH_C);
      rdy_out    = rst_n && (state_q == WAIT) && head_rdy;
      sel_left   = sel_left_q;
      sel_right  = sel_right_q;
      done_left  = rst_n && done_fwd && sel_left_q && (state_q == GRANT);
      done_right = rst_n && done_fwd && sel_right_q && (state_q == GRANT);
      overflow   = overflow_q;
   end

endmodule

// File: tb/tb_packet_order_arb.sv
// Self-checking bench for packet_order_arb: a queue-based model checked on
// every negedge, directed scenarios with literal expectations, and a
// two-level tree checking the leaf forwarding order.
`timescale 1ns/1ps
module tb_packet_order_arb;

   localparam int DL2   = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT stimulus
   logic rst_n = 1'b0;
   logic choice_push = 1'b0, choice_in = 1'b0;
   logic rdy_left = 1'b0, rdy_right = 1'b0, grant_in = 1'b1, done_fwd = 1'b0;
   logic full, rdy_out, sel_left, sel_right, done_left, done_right, overflow;

   // Tree stimulus / observation
   logic t_push_root = 1'b0, t_ch_root = 1'b0;
   logic t_push_l = 1'b0, t_ch_l = 1'b0;
   logic t_push_r = 1'b0, t_ch_r = 1'b0;
   logic t_fwd_done = 1'b0;
   logic r_full, r_rdy, r_sel_l, r_sel_r, r_done_l, r_done_r, r_ovf;
   logic l_full, l_rdy, a_sel, b_sel, l_done_l, l_done_r, l_ovf;
   logic q_full, q_rdy, c_sel, d_sel, q_done_l, q_done_r, q_ovf;

`ifdef PACKET_ORDER_ARB_STATS_EN
   logic [31:0] fwd_count, r_cnt, l_cnt, q_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   packet_order_arb #(.DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst_n(rst_n), .choice_push(choice_push), .choice_in(choice_in),
      .full(full), .rdy_left(rdy_left), .rdy_right(rdy_right), .grant_in(grant_in),
      .rdy_out(rdy_out), .sel_left(sel_left), .sel_right(sel_right),
      .done_fwd(done_fwd), .done_left(done_left), .done_right(done_right),
      .overflow(overflow)
`ifdef PACKET_ORDER_ARB_STATS_EN
      , .fwd_count(fwd_count)
`endif
   );

   packet_order_arb u_root (
      .clk(clk), .rst_n(rst_n), .choice_push(t_push_root), .choice_in(t_ch_root),
      .full(r_full), .rdy_left(l_rdy), .rdy_right(q_rdy), .grant_in(1'b1),
      .rdy_out(r_rdy), .sel_left(r_sel_l), .sel_right(r_sel_r),
      .done_fwd(t_fwd_done), .done_left(r_done_l), .done_right(r_done_r),
      .overflow(r_ovf)
`ifdef PACKET_ORDER_ARB_STATS_EN
      , .fwd_count(r_cnt)
`endif
   );

   packet_order_arb u_left (
      .clk(clk), .rst_n(rst_n), .choice_push(t_push_l), .choice_in(t_ch_l),
      .full(l_full), .rdy_left(1'b1), .rdy_right(1'b1), .grant_in(r_sel_l),
      .rdy_out(l_rdy), .sel_left(a_sel), .sel_right(b_sel),
      .done_fwd(r_done_l), .done_left(l_done_l), .done_right(l_done_r),
      .overflow(l_ovf)
`ifdef PACKET_ORDER_ARB_STATS_EN
      , .fwd_count(l_cnt)
`endif
   );

   packet_order_arb u_right (
      .clk(clk), .rst_n(rst_n), .choice_push(t_push_r), .choice_in(t_ch_r),
      .full(q_full), .rdy_left(1'b1), .rdy_right(1'b1), .grant_in(r_sel_r),
      .rdy_out(q_rdy), .sel_left(c_sel), .sel_right(d_sel),
      .done_fwd(r_done_r), .done_left(q_done_l), .done_right(q_done_r),
      .overflow(q_ovf)
`ifdef PACKET_ORDER_ARB_STATS_EN
      , .fwd_count(q_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the main DUT ----------------
   // m_q: queued choices in order; m_offer: head being offered upstream;
   // m_gr: side currently routed (-1 none); m_ovf: sticky drop flag.
   bit m_q[$];
   bit m_offer = 1'b0;
   int m_gr    = -1;
   bit m_ovf   = 1'b0;
   int m_pops  = 0;

   initial forever begin
      int  sz;
      bit  acc;
      bit  hrdy;
      bit  was_done;
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_offer = 1'b0;
         m_gr    = -1;
         m_ovf   = 1'b0;
         m_pops  = 0;
      end else begin
         sz       = m_q.size();
         acc      = choice_push && (sz < DEPTH);
         hrdy     = (sz > 0) && (m_q[0] ? rdy_right : rdy_left);
         was_done = 1'b0;
         if (choice_push && !acc) m_ovf = 1'b1;
         if (m_gr >= 0) begin
            if (done_fwd) begin
               void'(m_q.pop_front());
               m_pops++;
               m_gr     = -1;
               was_done = 1'b1;
            end
         end else if (m_offer) begin
            if (hrdy && grant_in) begin
               m_gr    = int'(m_q[0]);
               m_offer = 1'b0;
            end
         end else if (sz != 0) begin
            m_offer = 1'b1;
         end
         if (acc) m_q.push_back(choice_in);
         if (was_done) m_offer = (m_q.size() != 0);
      end
   end

   // Compare process: every negedge, DUT outputs against the model
   initial forever begin
      bit e_full, e_rdy, e_dl, e_dr;
      @(negedge clk);
      e_full = rst_n && (m_q.size() == DEPTH);
      e_rdy  = rst_n && m_offer && (m_q.size() > 0) && (m_q[0] ? rdy_right : rdy_left);
      e_dl   = rst_n && (m_gr == 0) && done_fwd;
      e_dr   = rst_n && (m_gr == 1) && done_fwd;
      check("full", full, e_full);
      check("rdy_out", rdy_out, e_rdy);
      check("sel_left", sel_left, m_gr == 0);
      check("sel_right", sel_right, m_gr == 1);
      check("done_left", done_left, e_dl);
      check("done_right", done_right, e_dr);
      check("overflow", overflow, m_ovf);
`ifdef PACKET_ORDER_ARB_STATS_EN
      check("fwd_count", fwd_count, m_pops);
`endif
      check("tree_leaf_excl", ($countones({a_sel, b_sel, c_sel, d_sel}) > 1), 0);
      check("tree_root_excl", r_sel_l & r_sel_r, 0);
   end

   // ---------------- directed stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic c);
      choice_push = 1'b1;
      choice_in   = c;
      tick();
      choice_push = 1'b0;
   endtask

   // Wait (bounded) for a grant, then check which side it went to
   task automatic wait_grant(input string name, input logic side);
      int n = 0;
      while (!(sel_left || sel_right) && n < 30) begin
         tick();
         n++;
      end
      check(name, {30'd0, sel_right, sel_left}, side ? 32'd2 : 32'd1);
   endtask

   // One-cycle done_fwd; expects a done pulse on the granted side
   task automatic done_pulse(input string name, input logic side);
      done_fwd = 1'b1;
      #1;
      check({name, "_done"}, {30'd0, done_right, done_left}, side ? 32'd2 : 32'd1);
      tick();
      done_fwd = 1'b0;
      check({name, "_rel"}, {30'd0, sel_right, sel_left}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int leaf;
      int n;
      int exp_order[4];
      exp_order = '{0, 2, 3, 1};

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_full", full, 0);
      check("rst_rdy_out", rdy_out, 0);
      check("rst_sel", {sel_right, sel_left}, 0);
      check("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      tick();

      // In-order grants: head waits for its own child only
      rdy_right = 1'b1;
      push(1'b0);
      push(1'b1);
      push(1'b0);
      repeat (4) tick();
      check("no_grant_before_left", {sel_right, sel_left}, 0);
      check("rdy_out_head_left_low", rdy_out, 0);
      rdy_left = 1'b1;
      #1;
      check("rdy_out_comb", rdy_out, 1);
      tick();
      check("rdy_to_grant_1cyc", {sel_right, sel_left}, 2'b01);
      done_pulse("g1", 1'b0);
      tick();
      check("b2b_one_wait", {sel_right, sel_left}, 2'b10);
      done_pulse("g2", 1'b1);
      wait_grant("g3", 1'b0);
      done_pulse("g3", 1'b0);
`ifdef PACKET_ORDER_ARB_STATS_EN
      check("fwd_count_3", fwd_count, 3);
`endif
      rdy_left  = 1'b0;
      rdy_right = 1'b0;
      tick();

      // Fill to full and overflow
      push(1'b0);
      push(1'b0);
      push(1'b0);
      check("not_full_at_3", full, 0);
      push(1'b0);
      check("full_at_4", full, 1);
      check("no_ovf_at_4", overflow, 0);
      push(1'b0);
      check("ovf_after_5th", overflow, 1);
      check("still_full", full, 1);
      repeat (3) tick();
      check("ovf_sticky", overflow, 1);

      // Push and pop together while full: push dropped, count drops to 3
      rdy_left = 1'b1;
      wait_grant("full_grant", 1'b0);
      choice_push = 1'b1;
      choice_in   = 1'b1;
      done_fwd    = 1'b1;
      #1;
      check("full_pop_done", done_left, 1);
      tick();
      choice_push = 1'b0;
      done_fwd    = 1'b0;
      check("count3_not_full", full, 0);
      check("count3_ovf", overflow, 1);
      push(1'b0);
      check("count4_again", full, 1);
      for (int i = 0; i < 4; i++) begin
         wait_grant("drain", 1'b0);
         done_pulse("drain", 1'b0);
`ifdef PACKET_ORDER_ARB_STATS_EN
         if (i == 2) check("fwd_count_7", fwd_count, 7);
`endif
      end
      rdy_left = 1'b0;
      tick();

      // Reset in the middle of a grant with three entries queued
      push(1'b0);
      push(1'b1);
      push(1'b0);
      rdy_left = 1'b1;
      wait_grant("pre_rst", 1'b0);
      rst_n    = 1'b0;
      done_fwd = 1'b1;
      #1;
      check("rst_done_masked", {done_right, done_left}, 0);
      check("rst_full_masked", full, 0);
      tick();
      rst_n = 1'b1;
      check("post_rst_sel", {sel_right, sel_left}, 0);
      check("post_rst_ovf", overflow, 0);
      check("post_rst_done", {done_right, done_left}, 0);
      tick();
      done_fwd = 1'b0;
      repeat (3) tick();
      check("post_rst_empty", {rdy_out, sel_right, sel_left}, 0);
`ifdef PACKET_ORDER_ARB_STATS_EN
      check("fwd_count_rst", fwd_count, 0);
`endif
      rdy_left = 1'b0;
      tick();

      // Two-level tree: root order L,R,R,L; leaves A,B under L and C,D under R
      t_push_root = 1'b1; t_ch_root = 1'b0; t_push_l = 1'b1; t_ch_l = 1'b0; tick();
      t_push_l = 1'b0;
      t_ch_root = 1'b1; t_push_r = 1'b1; t_ch_r = 1'b0; tick();
      t_ch_root = 1'b1; t_push_r = 1'b1; t_ch_r = 1'b1; tick();
      t_push_r = 1'b0;
      t_ch_root = 1'b0; t_push_l = 1'b1; t_ch_l = 1'b1; tick();
      t_push_root = 1'b0; t_push_l = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!(a_sel || b_sel || c_sel || d_sel) && n < 40) begin
            tick();
            n++;
         end
         leaf = a_sel ? 0 : b_sel ? 1 : c_sel ? 2 : d_sel ? 3 : 4;
         check($sformatf("tree_order_%0d", i), leaf, exp_order[i]);
         t_fwd_done = 1'b1;
         tick();
         t_fwd_done = 1'b0;
      end
      repeat (4) tick();
      check("tree_idle", {r_rdy, r_full, l_full, q_full, r_ovf, l_ovf, q_ovf}, 0);
      check("tree_no_done", {l_done_l, l_done_r, q_done_l, q_done_r}, 0);
`ifdef PACKET_ORDER_ARB_STATS_EN
      check("tree_counts", {r_cnt[7:0], l_cnt[7:0], q_cnt[7:0]}, {8'd4, 8'd2, 8'd2});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
